// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and state type
// for the 3x3 convolution window sequencer.
package conv_pkg;

  localparam int CONV_DATA_W   = 8;
  localparam int CONV_WIN_W    = 9 * CONV_DATA_W;
  localparam int CONV_FILT_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/conv_col_shift3.sv
// conv_col_shift3: three-column window register.
// New columns enter on the right; oldest leaves on the left.
module conv_col_shift3 #(
  parameter int DATA_W = conv_pkg::CONV_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [3*DATA_W-1:0] col_in,
  output logic [9*DATA_W-1:0] win
);

  import conv_pkg::*;

  logic [3*DATA_W-1:0] c0;
  logic [3*DATA_W-1:0] c1;
  logic [3*DATA_W-1:0] c2;

  // shift the returned column in as column2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (clr) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (en) begin
      c0 <= c1;
      c1 <= c2;
      c2 <= col_in;
    end
  end

  // window row r holds pixel r of each column,
  // column0 in the top byte of the row
  for (genvar r = 0; r < 3; r++) begin : g_row
    localparam int CH = (3 - r) * DATA_W - 1;
    localparam int WH = (9 - 3 * r) * DATA_W - 1;
    assign win[WH -: 3*DATA_W] = {
      c0[CH -: DATA_W],
      c1[CH -: DATA_W],
      c2[CH -: DATA_W]
    };
  end

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// conv3x3_window_ctrl: sweeps the column memory,
// feeds the 3x3 filter and tags results with addresses.
module conv3x3_window_ctrl #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int DATA_W   = conv_pkg::CONV_DATA_W,
  parameter int ADDR_W   = 10,
  parameter int OADDR_W  = 10,
  parameter int FILT_LAT = conv_pkg::CONV_FILT_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                col_rd_en,
  output logic [ADDR_W-1:0]   col_rd_addr,
  input  logic [3*DATA_W-1:0] col_rd_data,
  output logic [9*DATA_W-1:0] win_matrix,
  output logic                filt_ena,
  input  logic [2*DATA_W-1:0] filt_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic [OADDR_W-1:0]  out_addr
);

  import conv_pkg::*;

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int NRES = (IMG_W - 2) * (IMG_H - 2);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 3);
  localparam logic [XW-1:0] X_MIN  = XW'(2);
  localparam logic [OADDR_W-1:0] O_LAST = OADDR_W'(NRES - 1);

  state_t state_q;
  state_t state_d;

  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic               pend_q;
  logic [XW-1:0]      pend_x_q;
  logic [FILT_LAT:0]  vpipe_q;
  logic [OADDR_W-1:0] oaddr_q;

  logic stall;
  logic active;
  logic rd_last;
  logic shift_en;
  logic accept;
  logic pipe_empty;

  assign out_valid  = vpipe_q[FILT_LAT];
  assign stall      = out_valid & ~out_ready;
  assign accept     = out_valid & out_ready;
  assign active     = (state_q == RUN) | (state_q == DRAIN);
  assign col_rd_en  = (state_q == RUN) & ~stall;
  assign filt_ena   = active & ~stall;
  assign rd_last    = (x_q == X_LAST) & (y_q == Y_LAST);
  assign shift_en   = pend_q & filt_ena;
  assign pipe_empty = ~pend_q & ~|vpipe_q[FILT_LAT-1:0];

  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign out_addr = oaddr_q;
  assign out_data = out_valid ? filt_out : '0;

  // columns are stored row-major, so y*W+x is linear
  assign col_rd_addr =
    ADDR_W'(int'(y_q) * IMG_W + int'(x_q));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state; abort overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (col_rd_en & rd_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty & ~stall) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) state_d = IDLE;
  end

  // x/y read position, one step per issued read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (abort | (state_q == IDLE)) begin
      x_q <= '0;
      y_q <= '0;
    end else if (col_rd_en) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= rd_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // pending column and valid pipe; frozen while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      vpipe_q  <= '0;
    end else if (abort) begin
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      vpipe_q  <= '0;
    end else if (filt_ena) begin
      pend_q   <= col_rd_en;
      pend_x_q <= x_q;
      vpipe_q  <= {vpipe_q[FILT_LAT-1:0],
                   pend_q & (pend_x_q >= X_MIN)};
    end
  end

  // output address counts accepted results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oaddr_q <= '0;
    end else if (abort | ((state_q == IDLE) & start)) begin
      oaddr_q <= '0;
    end else if (accept) begin
      oaddr_q <= (oaddr_q == O_LAST) ? '0
               : oaddr_q + OADDR_W'(1);
    end
  end

  conv_col_shift3 #(
    .DATA_W (DATA_W)
  ) u_win (
    .clk    (clk),
    .rst    (rst),
    .en     (shift_en),
    .clr    (abort),
    .col_in (col_rd_data),
    .win    (win_matrix)
  );

endmodule

// File: tb/tb_conv3x3_window_ctrl.sv
// tb_conv3x3_window_ctrl: scoreboard bench for the
// 3x3 window sequencer on 5x5 and 3x3 images.
module tb_conv3x3_window_ctrl;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 5x5 instance
  logic        start, abort, busy, done;
  logic        col_rd_en, filt_ena, out_valid, out_ready;
  logic [9:0]  col_rd_addr, out_addr;
  logic [23:0] col_rd_data = '0;
  logic [71:0] win_matrix;
  logic [15:0] filt_out, out_data;

  // 3x3 instance
  logic        start3, abort3, busy3, done3;
  logic        col_rd_en3, filt_ena3, out_valid3, out_ready3;
  logic [9:0]  col_rd_addr3, out_addr3;
  logic [23:0] col_rd_data3 = '0;
  logic [71:0] win_matrix3;
  logic [15:0] filt_out3, out_data3;

  conv3x3_window_ctrl #(
    .IMG_W(5), .IMG_H(5), .DATA_W(8),
    .ADDR_W(10), .OADDR_W(10), .FILT_LAT(3)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .col_rd_en(col_rd_en), .col_rd_addr(col_rd_addr),
    .col_rd_data(col_rd_data), .win_matrix(win_matrix),
    .filt_ena(filt_ena), .filt_out(filt_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  conv3x3_window_ctrl #(
    .IMG_W(3), .IMG_H(3), .DATA_W(8),
    .ADDR_W(10), .OADDR_W(10), .FILT_LAT(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .busy(busy3), .done(done3),
    .col_rd_en(col_rd_en3), .col_rd_addr(col_rd_addr3),
    .col_rd_data(col_rd_data3), .win_matrix(win_matrix3),
    .filt_ena(filt_ena3), .filt_out(filt_out3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_addr(out_addr3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int acc5 = 0, done5 = 0, acc3 = 0, donec3 = 0;
  res_t q5[$];
  res_t q3[$];
  res_t e5, e3;
  logic done_prev = 1'b0;

  task automatic check(input string name,
                       input logic [71:0] act,
                       input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // pixel (y,x) = x+y; column word has top pixel in MSBs
  function automatic logic [23:0] col_word(
    input logic [9:0] a, input int w);
    int x, y;
    y = int'(a) / w;
    x = int'(a) % w;
    return {8'(x + y), 8'(x + y + 1), 8'(x + y + 2)};
  endfunction

  function automatic logic [15:0] win_sum(
    input logic [71:0] m);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 9; i++)
      s = s + 16'($signed(m[i*8 +: 8]));
    return s;
  endfunction

  // column memories, 1-cycle latency
  always @(posedge clk) begin
    if (col_rd_en)  col_rd_data  <= col_word(col_rd_addr, 5);
    if (col_rd_en3) col_rd_data3 <= col_word(col_rd_addr3, 3);
  end

  // 3-stage enable-gated sum-of-9 filter models
  logic [15:0] f1, f2, f3, g1, g2, g3;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f1 <= '0; f2 <= '0; f3 <= '0;
    end else if (filt_ena) begin
      f1 <= win_sum(win_matrix); f2 <= f1; f3 <= f2;
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= '0; g2 <= '0; g3 <= '0;
    end else if (filt_ena3) begin
      g1 <= win_sum(win_matrix3); g2 <= g1; g3 <= g2;
    end
  end
  assign filt_out  = f3;
  assign filt_out3 = g3;

  // monitor for the 5x5 instance
  always @(negedge clk) begin
    if (out_valid) begin
      if (q5.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got addr %0d data %0d expected none",
                 out_addr, out_data);
      end else begin
        e5 = q5[0];
        check("res_addr", {62'b0, out_addr}, {62'b0, e5.addr});
        check("res_data", {56'b0, out_data}, {56'b0, e5.data});
        if (out_ready && !abort) begin
          void'(q5.pop_front());
          acc5++;
        end else if (!out_ready) begin
          check("stall_rd_en", {71'b0, col_rd_en}, 72'd0);
          check("stall_filt_ena", {71'b0, filt_ena}, 72'd0);
        end
      end
    end
    if (done_prev)
      check("busy_after_done", {71'b0, busy}, 72'd0);
    if (done) done5++;
    done_prev = done;
  end

  // monitor for the 3x3 instance
  always @(negedge clk) begin
    if (out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result3: got addr %0d data %0d expected none",
                 out_addr3, out_data3);
      end else begin
        e3 = q3.pop_front();
        check("res3_addr", {62'b0, out_addr3}, {62'b0, e3.addr});
        check("res3_data", {56'b0, out_data3}, {56'b0, e3.data});
        acc3++;
      end
    end
    if (done3) donec3++;
  end

  // 5x5 output window (oy,ox) sums to 9*(ox+oy+2)
  task automatic push_frame5();
    res_t r;
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++) begin
        r.addr = 10'(oy * 3 + ox);
        r.data = 16'(9 * (ox + oy + 2));
        q5.push_back(r);
      end
  endtask

  // mode 0: ready=1, 1: random ready, 2: start pulses while busy
  task automatic run_frame(input int mode, input string tag);
    bit fin;
    push_frame5();
    acc5  = 0;
    done5 = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (mode != 1 && cyc == 3)
        check({tag, "_win00"}, win_matrix,
              72'h00_01_02_01_02_03_02_03_04);
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (mode == 2 && cyc < 15 && (cyc % 5) == 2);
      if (done5 > 0 && !busy) fin = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_finished"}, {71'b0, fin}, 72'd1);
    check({tag, "_count"}, 72'(acc5), 72'd9);
    check({tag, "_done_once"}, 72'(done5), 72'd1);
    check({tag, "_queue_empty"}, 72'(q5.size()), 72'd0);
    q5.delete();
  endtask

  initial begin
    bit fin;
    res_t r;
    start = 1'b0;  abort = 1'b0;  out_ready = 1'b1;
    start3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {71'b0, busy}, 72'd0);
    check("rst_done", {71'b0, done}, 72'd0);
    check("rst_rd_en", {71'b0, col_rd_en}, 72'd0);
    check("rst_filt_ena", {71'b0, filt_ena}, 72'd0);
    check("rst_valid", {71'b0, out_valid}, 72'd0);
    check("rst_addr", {62'b0, out_addr}, 72'd0);
    check("rst_win", win_matrix, 72'd0);
    check("rst_data", {56'b0, out_data}, 72'd0);
    rst = 1'b0;

    run_frame(0, "plain");
    run_frame(1, "backpressure");

    // abort after the 4th accepted result
    push_frame5();
    acc5 = 0;
    done5 = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (acc5 == 4) fin = 1'b1;
    end
    check("abort_reach4", {71'b0, fin}, 72'd1);
    abort = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b1;
    check("abort_busy", {71'b0, busy}, 72'd0);
    check("abort_valid", {71'b0, out_valid}, 72'd0);
    check("abort_addr", {62'b0, out_addr}, 72'd0);
    check("abort_left", 72'(q5.size()), 72'd5);
    q5.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 72'(done5), 72'd0);
    run_frame(0, "after_abort");

    // asynchronous reset in the middle of RUN
    push_frame5();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_busy", {71'b0, busy}, 72'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {71'b0, busy}, 72'd0);
    check("midrst_rd_en", {71'b0, col_rd_en}, 72'd0);
    check("midrst_filt_ena", {71'b0, filt_ena}, 72'd0);
    check("midrst_valid", {71'b0, out_valid}, 72'd0);
    check("midrst_addr", {62'b0, out_addr}, 72'd0);
    check("midrst_rd_addr", {62'b0, col_rd_addr}, 72'd0);
    check("midrst_win", win_matrix, 72'd0);
    q5.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0, "after_rst");

    run_frame(2, "start_busy");

    // 3x3 image: one window, sum 18 at address 0
    r.addr = 10'd0;
    r.data = 16'd18;
    q3.push_back(r);
    acc3 = 0;
    donec3 = 0;
    @(posedge clk); #1; start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (donec3 > 0 && !busy3) fin = 1'b1;
    end
    check("img3_finished", {71'b0, fin}, 72'd1);
    check("img3_count", 72'(acc3), 72'd1);
    check("img3_done_once", 72'(donec3), 72'd1);
    check("img3_queue_empty", 72'(q3.size()), 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
